// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter slice.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Width of an index into n lanes; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a hold counter that must reach max_hold; never less than one bit.
    function automatic int cnt_w(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_if.sv
// Per-lane request/grant handshake between a requester and the arbiter.
interface arb_if;
    logic req;
    logic last;
    logic gnt;

    modport P_ARB (input req, input last, output gnt);
    modport P_REQ (output req, output last, input gnt);
endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first requesting lane at or after ptr, wrapping modulo SIZE.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int SIZE  = 8,
    localparam int IDX_W = idx_w(SIZE)
) (
    input  logic [SIZE-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Lane sitting at rotation offset off from base; explicit wrap keeps
    // non-power-of-two sizes inside 0..SIZE-1.
    function automatic int lane_at(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= SIZE) s = s - SIZE;
        return s;
    endfunction

    logic [SIZE-1:0] rot;

    // Rotate the request vector so the highest-priority lane lands at bit 0.
    always_comb begin
        rot = '0;
        for (int j = 0; j < SIZE; j++) begin
            rot[j] = req[lane_at(ptr, j)];
        end
    end

    // Priority-encode the rotated vector; scanning downward lets the lowest offset win.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = SIZE - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                idx   = IDX_W'(lane_at(ptr, j));
            end
        end
    end

endmodule

// File: rtl/svi_rr_arbiter.sv
// Round-robin arbiter over an array of arb_if lanes: one grantee at a time,
// tenure ends on release, last beat or hold limit, then one dead cycle.
module svi_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int SIZE     = 8,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = idx_w(SIZE)
) (
    input  logic             i_clk,
    input  logic             i_srst,
    arb_if.P_ARB             p_arb [SIZE-1:0],
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam int             CNT_W      = cnt_w(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
    localparam bit             TIMEOUT_EN = (MAX_HOLD != 0);

    logic [SIZE-1:0]  req_v;
    logic [SIZE-1:0]  last_v;

    arb_state_e       state_q, state_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             busy_q, busy_n;
    logic             to_q, to_n;
    logic [SIZE-1:0]  gnt_q, gnt_n;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             end_rel;
    logic             end_last;
    logic             end_limit;

    // Flatten the lane array into vectors and fan the registered one-hot back out.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        assign req_v[i]     = p_arb[i].req;
        assign last_v[i]    = p_arb[i].last;
        assign p_arb[i].gnt = gnt_q[i];
    end

    rr_pick #(
        .SIZE (SIZE)
    ) u_pick (
        .req   (req_v),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Tenure-end conditions for the current grantee.
    always_comb begin
        end_rel   = ~req_v[idx_q];
        end_last  = req_v[idx_q] & last_v[idx_q];
        end_limit = TIMEOUT_EN && (cnt_q == CNT_MAX);
    end

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        busy_n  = busy_q;
        to_n    = 1'b0;
        gnt_n   = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_n = GRANT;
                    idx_n   = pick_idx;
                    busy_n  = 1'b1;
                    cnt_n   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (end_rel || end_last || end_limit) begin
                    state_n = GAP;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    ptr_n   = (idx_q == IDX_W'(SIZE - 1)) ? '0 : idx_q + IDX_W'(1);
                    // A timeout is reported only when the requester did not end it itself.
                    to_n    = end_limit && !end_rel && !end_last;
                end else if (cnt_q != '1) begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        for (int i = 0; i < SIZE; i++) begin
            gnt_n[i] = busy_n && (idx_n == IDX_W'(i));
        end
    end

    // State and output registers; reset wins over any tenure in progress.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            busy_q  <= busy_n;
            to_q    <= to_n;
            gnt_q   <= gnt_n;
        end
    end

    assign o_gnt_idx = idx_q;
    assign o_busy    = busy_q;
    assign o_timeout = to_q;

endmodule

// File: tb/tb_svi_rr_arbiter.sv
// Bench for svi_rr_arbiter with four lanes and a hold limit of four.
module tb_svi_rr_arbiter;

    localparam int SIZE     = 4;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_v;
    logic [3:0] last_v;
    logic [3:0] gnt_v;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    arb_if lanes [SIZE-1:0] ();

    for (genvar g = 0; g < SIZE; g++) begin : g_drv
        assign lanes[g].req  = req_v[g];
        assign lanes[g].last = last_v[g];
        assign gnt_v[g]      = lanes[g].gnt;
    end

    svi_rr_arbiter #(
        .SIZE     (SIZE),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .i_clk     (clk),
        .i_srst    (rst),
        .p_arb     (lanes),
        .o_gnt_idx (gnt_idx),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    // Reference: who owns the resource, for how long, whether a dead cycle is
    // pending, and which lane has first claim next.
    int         m_owner;
    int         m_held;
    bit         m_dead;
    int         m_first;
    logic [3:0] e_gnt;
    logic       e_busy;
    logic       e_to;
    logic [1:0] e_idx;

    task automatic model_edge();
        bit released;
        bit limited;
        e_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_dead  = 1'b0;
            m_first = 0;
            e_idx   = 2'd0;
        end else if (m_owner >= 0) begin
            released = !req_v[m_owner] || last_v[m_owner];
            limited  = (m_held == MAX_HOLD);
            e_to     = limited && !released;
            if (released || limited) begin
                m_first = (m_owner + 1) % SIZE;
                m_owner = -1;
                m_held  = 0;
                m_dead  = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end else if (m_dead) begin
            m_dead = 1'b0;
        end else begin
            for (int off = 0; off < SIZE; off++) begin
                int lane;
                lane = (m_first + off) % SIZE;
                if (req_v[lane]) begin
                    m_owner = lane;
                    m_held  = 1;
                    e_idx   = 2'(lane);
                    break;
                end
            end
        end
        e_busy = (m_owner >= 0);
        e_gnt  = e_busy ? (4'b0001 << m_owner) : 4'b0000;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model on the edge, then sample outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        n_vec++;
        if ($countones(gnt_v) > 1) begin
            n_err++;
            $display("FAIL onehot: got %b expected at most one bit set", gnt_v);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] gnt;
        logic       busy;
        logic       to;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                       input logic [3:0] g, input logic b, input logic t, input logic [1:0] ix);
        vec_t v;
        v.rst = r; v.req = rq; v.last = ls; v.gnt = g; v.busy = b; v.to = t; v.idx = ix;
        tbl.push_back(v);
    endtask

    initial begin
        rst    = 1'b1;
        req_v  = 4'b0000;
        last_v = 4'b0000;

        // Reset, then lane 2 granted and reset mid-tenure; lanes 1 and 3 then contend.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 1, 0, 2);
        add(0, 4'b0100, 4'b0000, 4'b0100, 1, 0, 2);
        add(1, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1010, 4'b0000, 4'b0010, 1, 0, 1);
        // Lane 1 never asserts last: four granted cycles, then timeout.
        add(0, 4'b1010, 4'b0000, 4'b0010, 1, 0, 1);
        add(0, 4'b1010, 4'b0000, 4'b0010, 1, 0, 1);
        add(0, 4'b1010, 4'b0000, 4'b0010, 1, 0, 1);
        add(0, 4'b1010, 4'b0000, 4'b0000, 0, 1, 0);
        add(0, 4'b1010, 4'b0000, 4'b0000, 0, 0, 0);
        // Pointer now 2: lane 3 wins, then drops out after one cycle.
        add(0, 4'b1010, 4'b0000, 4'b1000, 1, 0, 3);
        add(0, 4'b0011, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0011, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0011, 4'b0000, 4'b0001, 1, 0, 0);
        // Lane 0 asserts last on the limit cycle: no timeout.
        add(0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // Move pointer to 3 via a lane 2 tenure; lane 2 alone then wins via wrap.
        add(0, 4'b0100, 4'b0000, 4'b0100, 1, 0, 2);
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 1, 0, 2);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // Fairness: all lanes request, each releases with last on its 2nd cycle.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        for (int k = 0; k < SIZE; k++) begin
            add(0, 4'b1111, 4'b0000, 4'b0001 << k, 1, 0, 2'(k));
            add(0, 4'b1111, 4'b0000, 4'b0001 << k, 1, 0, 2'(k));
            add(0, 4'b1111, 4'b0001 << k, 4'b0000, 0, 0, 0);
            add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
        end
        add(0, 4'b1111, 4'b0000, 4'b0001, 1, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

        foreach (tbl[i]) begin
            rst    = tbl[i].rst;
            req_v  = tbl[i].req;
            last_v = tbl[i].last;
            step();
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt_v), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].to));
            if (tbl[i].busy || tbl[i].rst)
                chk($sformatf("tbl%0d_idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
        end

        // Single requester holding req with last: granted one cycle in every three.
        rst    = 1'b1;
        req_v  = 4'b0000;
        last_v = 4'b0000;
        step();
        rst    = 1'b0;
        req_v  = 4'b0010;
        last_v = 4'b0010;
        for (int r = 0; r < 3; r++) begin
            step();
            chk($sformatf("solo%0d_grant", r), 32'(gnt_v), 32'(4'b0010));
            chk($sformatf("solo%0d_idx", r), 32'(gnt_idx), 32'd1);
            step();
            chk($sformatf("solo%0d_gap", r), 32'(gnt_v), 32'd0);
            step();
            chk($sformatf("solo%0d_idle", r), 32'(gnt_v), 32'd0);
        end

        // Random traffic against the reference model, with occasional resets.
        rst    = 1'b1;
        req_v  = 4'b0000;
        last_v = 4'b0000;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int l = 0; l < SIZE; l++) begin
                if ($urandom_range(0, 7) == 0) req_v[l] = ~req_v[l];
                last_v[l] = ($urandom_range(0, 3) == 0);
            end
            step();
            chk($sformatf("rnd%0d_gnt", c), 32'(gnt_v), 32'(e_gnt));
            chk($sformatf("rnd%0d_busy", c), 32'(busy), 32'(e_busy));
            chk($sformatf("rnd%0d_timeout", c), 32'(timeout), 32'(e_to));
            if (e_busy)
                chk($sformatf("rnd%0d_idx", c), 32'(gnt_idx), 32'(e_idx));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/svi_rr_arbiter.md
Name: svi_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among SIZE requesters.
- Each requester connects through one element of an SVI array port, mirroring the array-of-interfaces style used by the latch datapath blocks.
- Grants one requester at a time, holds the grant until release or timeout, then rotates priority.
- Sits between the per-lane interface array in top and the shared resource; exposes the winning index and a busy flag to the resource mux.

Parameters:
- SIZE, 8, number of requesters / interface array elements (>=2).
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure; 0 disables the timeout.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_srst  input  1  reset; synchronous, active-high.
- p_arb[SIZE-1:0]  interface  arb_if.P_ARB array  per-requester handshake; the modport has input req, input last, output gnt.
- o_gnt_idx  output  $clog2(SIZE)  index of the current grantee; valid only while o_busy=1.
- o_busy  output  1  a grant is active this cycle.
- o_timeout  output  1  one-cycle pulse when a tenure is force-ended by MAX_HOLD.

Behaviour:
- Reset (i_srst=1 at an edge) sets:
  - state=IDLE, all p_arb[i].gnt=0, o_busy=0, o_gnt_idx=0, o_timeout=0;
  - priority pointer ptr=0, hold counter cnt=0.
- Reset has priority over every other event, including mid-tenure. The grant drops on the edge where reset is sampled.
- All outputs are registered. gnt is one-hot or all-zero; it is never multi-hot.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any req is high, select the first index k scanning ptr, ptr+1, ..., SIZE-1, 0, ..., ptr-1 (modulo SIZE).
  - Next cycle: state=GRANT, gnt[k]=1, o_gnt_idx=k, o_busy=1, cnt=1.
  - Latency from req high in IDLE to gnt high is 1 cycle.
  - With no req high, stay in IDLE.
- GRANT (grantee k): the tenure ends at this edge if any of the following holds:
  - (a) req[k]=0;
  - (b) req[k]=1 and last[k]=1; the last beat is granted in this cycle, and gnt drops on the next cycle;
  - (c) MAX_HOLD!=0 and cnt==MAX_HOLD; o_timeout pulses for the next cycle.
- On tenure end: gnt[k]=0, o_busy=0, ptr=(k+1) mod SIZE, cnt=0, state=GAP.
- Otherwise stay in GRANT and increment cnt. cnt saturates and never wraps; width is $clog2(MAX_HOLD+1), minimum 1.
- GAP:
  - Exactly one dead cycle with all gnt=0, guaranteeing no grant overlap at handoff. Always goes to IDLE.
  - req is ignored during GAP.
  - Net handoff: grantee A's gnt low to grantee B's gnt high is 2 cycles.
- Simultaneous events:
  - When (a), (b) and (c) coincide, o_timeout pulses only if (a) and (b) are both false.
  - ptr advances past k after every tenure end, so a requester that re-asserts immediately loses to any other pending requester.
- Requests from non-granted lanes during GRANT are held pending, not latched; a requester must keep req high to be considered.
- Single requester: re-granted every third cycle window (GRANT, GAP, IDLE-select) while it keeps requesting.
- ptr wraps from SIZE-1 to 0.
- SIZE that is not a power of two: the modulo is explicit, and ptr never takes values >= SIZE.

Decomposition:
- Package arb_pkg:
  - state enum arb_state_e {IDLE, GRANT, GAP};
  - localparam-derived index width helper.
- Interface arb_if (in its own file) carries signals req, last, gnt:
  - modport P_ARB (input req, input last, output gnt);
  - modport P_REQ (output req, output last, input gnt).
- One sub-module, rr_pick: purely combinational. Inputs: req vector and ptr. Outputs: found flag and index k, rotate-then-priority-encode.
- The top arbiter flattens p_arb[i].req and p_arb[i].last into vectors inside a generate loop, and drives p_arb[i].gnt from the registered one-hot.

Test Plan (SIZE=4, MAX_HOLD=4):
- Reset mid-tenure: grant lane 2, assert i_srst for 1 cycle -> next cycle all gnt=0, o_busy=0; subsequent req from lanes 1 and 3 -> lane 1 granted (ptr=0).
- Fairness: lanes 0–3 all hold req continuously, each pulses last on its 2nd granted cycle -> grant order 0,1,2,3,0; each tenure 2 cycles; each handoff has a 1-cycle GAP plus 1 IDLE cycle.
- Timeout: lane 1 holds req, never asserts last -> gnt[1] high exactly 4 cycles, o_timeout=1 on the cycle gnt drops, ptr=2.
- Drop-out: lane 3 granted, deasserts req after 1 cycle -> gnt[3] low next cycle, o_timeout=0; lane 0 is next if requesting.
- Wrap and skip: ptr=3, only lane 2 requests -> lane 2 granted after a scan through 3,0,1; o_gnt_idx=2.
- Coincidence: on cycle cnt==4 lane 0 asserts last -> tenure ends, o_timeout stays 0; checker asserts gnt never multi-hot and never high during GAP.
